// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the multi-cycle control unit.
//   - widths of control flags, opcodes and the state code
//   - FSM state codes (FETCH 0 .. HALT 6)
//   - opcode values 0..17 (anything above 17 is undefined)
//   - encodings of the 2-bit control flags and the packed control vector
//   - small opcode-classification helpers used by the FSM and the decoder
package cu_pkg;

  localparam int FLAG_W = 2;  // width of every 2-bit control flag
  localparam int OP_W   = 6;  // opcode width
  localparam int ST_W   = 3;  // state code width

  typedef enum logic [ST_W-1:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_WAIT_IN = 3'd5,
    ST_HALT    = 3'd6
  } state_e;

  localparam logic [OP_W-1:0] OP_ALU    = 6'd0;
  localparam logic [OP_W-1:0] OP_LW     = 6'd1;
  localparam logic [OP_W-1:0] OP_LI     = 6'd2;
  localparam logic [OP_W-1:0] OP_SW     = 6'd3;
  localparam logic [OP_W-1:0] OP_SRL    = 6'd4;
  localparam logic [OP_W-1:0] OP_SLL    = 6'd5;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'd6;
  localparam logic [OP_W-1:0] OP_BNQ    = 6'd7;
  localparam logic [OP_W-1:0] OP_J      = 6'd8;
  localparam logic [OP_W-1:0] OP_JR     = 6'd9;
  localparam logic [OP_W-1:0] OP_JAL    = 6'd10;
  localparam logic [OP_W-1:0] OP_NOP    = 6'd11;
  localparam logic [OP_W-1:0] OP_HLT    = 6'd12;
  localparam logic [OP_W-1:0] OP_MOVE   = 6'd13;
  localparam logic [OP_W-1:0] OP_IN     = 6'd14;
  localparam logic [OP_W-1:0] OP_OUT    = 6'd15;
  localparam logic [OP_W-1:0] OP_LOADR  = 6'd16;
  localparam logic [OP_W-1:0] OP_STORER = 6'd17;

  // flagRF
  localparam logic [FLAG_W-1:0] RF_NONE  = 2'b00;
  localparam logic [FLAG_W-1:0] RF_WRITE = 2'b01;
  localparam logic [FLAG_W-1:0] RF_MOVE  = 2'b10;
  // flagALU
  localparam logic [FLAG_W-1:0] ALU_NONE  = 2'b00;
  localparam logic [FLAG_W-1:0] ALU_FUNCT = 2'b01;
  localparam logic [FLAG_W-1:0] ALU_SRL   = 2'b10;
  localparam logic [FLAG_W-1:0] ALU_SLL   = 2'b11;
  // flagPC
  localparam logic [FLAG_W-1:0] PC_HOLD = 2'b00;
  localparam logic [FLAG_W-1:0] PC_INC  = 2'b01;
  localparam logic [FLAG_W-1:0] PC_LOAD = 2'b10;
  // flagDM
  localparam logic [FLAG_W-1:0] DM_NONE  = 2'b00;
  localparam logic [FLAG_W-1:0] DM_READ  = 2'b01;
  localparam logic [FLAG_W-1:0] DM_WRITE = 2'b10;
  // flagMUXRD
  localparam logic [FLAG_W-1:0] MUXRD_ALU = 2'b00;
  localparam logic [FLAG_W-1:0] MUXRD_MEM = 2'b01;
  localparam logic [FLAG_W-1:0] MUXRD_IN  = 2'b10;
  localparam logic [FLAG_W-1:0] MUXRD_RA  = 2'b11;

  typedef struct packed {
    logic [FLAG_W-1:0] rf;
    logic [FLAG_W-1:0] alu;
    logic [FLAG_W-1:0] pc;
    logic [FLAG_W-1:0] dm;
    logic [FLAG_W-1:0] muxrd;
    logic              jr;
    logic              jal;
    logic              li;
    logic              rr;
    logic              in_ack;
    logic              out_valid;
  } ctrl_t;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_LOADR);
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_SW) || (op == OP_STORER);
  endfunction

  // Register-indirect memory forms keep flagRR up for the whole instruction.
  function automatic logic is_reg_indirect(input logic [OP_W-1:0] op);
    return (op == OP_LOADR) || (op == OP_STORER);
  endfunction

  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return op > OP_STORER;
  endfunction

  // ALU mode for the arithmetic/shift class; ALU_NONE for everything else.
  function automatic logic [FLAG_W-1:0] alu_mode(input logic [OP_W-1:0] op);
    case (op)
      OP_ALU:  return ALU_FUNCT;
      OP_SRL:  return ALU_SRL;
      OP_SLL:  return ALU_SLL;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational control decoder for the control unit.
// Maps the registered FSM state, latched opcode and latched branch result
// (plus in_valid, only consulted in WAIT_IN) onto the full control vector.
// All flags are zero in FETCH, DECODE and HALT.
// Ports:
//   state    in   current FSM state (registered)
//   op       in   opcode latched in DECODE
//   branch   in   compare result latched at the end of EXEC
//   in_valid in   IN bus word valid
//   ctrl     out  packed control flags
module cu_decode
  import cu_pkg::*;
(
  input  state_e          state,
  input  logic [OP_W-1:0] op,
  input  logic            branch,
  input  logic            in_valid,
  output ctrl_t           ctrl
);

  logic taken;

  always_comb begin
    // NOTE: every field gets a default first so no path through the case
    // leaves ctrl unassigned, which would otherwise infer a latch.
    ctrl  = '0;
    taken = (op == OP_BEQ) ? branch : !branch;

    case (state)
      ST_EXEC: begin
        ctrl.rr = is_reg_indirect(op);
        case (op)
          OP_ALU, OP_SRL, OP_SLL: ctrl.alu = alu_mode(op);
          OP_BEQ, OP_BNQ:         ctrl.alu = ALU_FUNCT;
          OP_J:                   ctrl.pc  = PC_LOAD;
          OP_JR: begin
            ctrl.pc = PC_LOAD;
            ctrl.jr = 1'b1;
          end
          OP_NOP:                 ctrl.pc  = PC_INC;
          OP_MOVE: begin
            ctrl.rf = RF_MOVE;
            ctrl.pc = PC_INC;
          end
          OP_OUT: begin
            ctrl.out_valid = 1'b1;
            ctrl.pc        = PC_INC;
          end
          default: ;
        endcase
      end

      ST_MEM: begin
        ctrl.rr = is_reg_indirect(op);
        if (is_load(op)) begin
          ctrl.dm = DM_READ;
        end else if (is_store(op)) begin
          // Stores retire out of MEM, so the PC advances here.
          ctrl.dm = DM_WRITE;
          ctrl.pc = PC_INC;
        end
      end

      ST_WB: begin
        ctrl.rr = is_reg_indirect(op);
        case (op)
          OP_ALU, OP_SRL, OP_SLL: begin
            ctrl.alu   = alu_mode(op);  // operands still need the ALU result
            ctrl.rf    = RF_WRITE;
            ctrl.muxrd = MUXRD_ALU;
            ctrl.pc    = PC_INC;
          end
          OP_LW, OP_LOADR: begin
            ctrl.dm    = DM_READ;
            ctrl.rf    = RF_WRITE;
            ctrl.muxrd = MUXRD_MEM;
            ctrl.pc    = PC_INC;
          end
          OP_LI: begin
            ctrl.li = 1'b1;
            ctrl.rf = RF_WRITE;
            ctrl.pc = PC_INC;
          end
          OP_BEQ, OP_BNQ: ctrl.pc = taken ? PC_LOAD : PC_INC;
          OP_JAL: begin
            // Return address write and target load share one edge.
            ctrl.jal   = 1'b1;
            ctrl.muxrd = MUXRD_RA;
            ctrl.rf    = RF_WRITE;
            ctrl.pc    = PC_LOAD;
          end
          default: ;
        endcase
      end

      ST_WAIT_IN: begin
        // Accepting is combinational on in_valid so a word already present
        // on entry is consumed in the first WAIT_IN cycle.
        if (in_valid) begin
          ctrl.in_ack = 1'b1;
          ctrl.rf     = RF_WRITE;
          ctrl.muxrd  = MUXRD_IN;
          ctrl.pc     = PC_INC;
        end
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for the processor datapath.
// Walks FETCH -> DECODE -> EXEC and then an opcode-specific path through
// MEM / WB / WAIT_IN back to FETCH, or into the absorbing HALT state.
// Optional feature: define CU_RETIRE_COUNT_EN to add the 32-bit 'retired'
// output counting completed instructions.
// Ports:
//   clock, reset (async, active-high)
//   opcode      current instruction opcode (sampled in DECODE)
//   flagBRANCH  compare result, 1 = operands equal (sampled at end of EXEC)
//   in_valid    IN bus word valid
//   State       current FSM state code
//   flagRF/ALU/PC/DM/MUXRD, flagJR/JAL/LI/RR   datapath controls
//   in_ack      one-cycle pulse, IN word consumed
//   out_valid   one-cycle pulse, OUT bus valid
//   halted      processor stopped
//   illegal     sticky, undefined opcode seen
//   retired     (CU_RETIRE_COUNT_EN only) completed-instruction count
module control_unit
  import cu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [OP_W-1:0]   opcode,
  input  logic              flagBRANCH,
  input  logic              in_valid,
  output logic [ST_W-1:0]   State,
  output logic [FLAG_W-1:0] flagRF,
  output logic [FLAG_W-1:0] flagALU,
  output logic [FLAG_W-1:0] flagPC,
  output logic [FLAG_W-1:0] flagDM,
  output logic [FLAG_W-1:0] flagMUXRD,
  output logic              flagJR,
  output logic              flagJAL,
  output logic              flagLI,
  output logic              flagRR,
  output logic              in_ack,
  output logic              out_valid,
  output logic              halted,
  output logic              illegal
`ifdef CU_RETIRE_COUNT_EN
  ,
  output logic [31:0]       retired
`endif
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            branch_q, branch_d;
  logic            illegal_q, illegal_d;
  logic            retiring;
  ctrl_t           ctrl;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        state_d = ST_EXEC;
        op_d    = opcode;
      end
      ST_EXEC: begin
        branch_d = flagBRANCH;
        if (is_illegal(op_q)) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else begin
          case (op_q)
            OP_ALU, OP_SRL, OP_SLL, OP_LI,
            OP_BEQ, OP_BNQ, OP_JAL:          state_d = ST_WB;
            OP_LW, OP_LOADR, OP_SW, OP_STORER: state_d = ST_MEM;
            OP_IN:                           state_d = ST_WAIT_IN;
            OP_HLT:                          state_d = ST_HALT;
            default:                         state_d = ST_FETCH;
          endcase
        end
      end
      ST_MEM:     state_d = is_load(op_q) ? ST_WB : ST_FETCH;
      ST_WB:      state_d = ST_FETCH;
      ST_WAIT_IN: if (in_valid) state_d = ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_FETCH;
    endcase

    // An instruction completes when any post-DECODE state returns to FETCH.
    retiring = (state_d == ST_FETCH) &&
               ((state_q == ST_EXEC) || (state_q == ST_MEM) ||
                (state_q == ST_WB)   || (state_q == ST_WAIT_IN));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      op_q      <= '0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
    end
  end

  cu_decode u_decode (
    .state    (state_q),
    .op       (op_q),
    .branch   (branch_q),
    .in_valid (in_valid),
    .ctrl     (ctrl)
  );

  assign State     = state_q;
  assign flagRF    = ctrl.rf;
  assign flagALU   = ctrl.alu;
  assign flagPC    = ctrl.pc;
  assign flagDM    = ctrl.dm;
  assign flagMUXRD = ctrl.muxrd;
  assign flagJR    = ctrl.jr;
  assign flagJAL   = ctrl.jal;
  assign flagLI    = ctrl.li;
  assign flagRR    = ctrl.rr;
  assign in_ack    = ctrl.in_ack;
  assign out_valid = ctrl.out_valid;
  assign halted    = (state_q == ST_HALT);
  assign illegal   = illegal_q;

`ifdef CU_RETIRE_COUNT_EN
  logic [31:0] retired_q, retired_d;

  // HALT never returns to FETCH, so the count freezes there on its own.
  always_comb begin
    retired_d = retired_q;
    if (retiring) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired = retired_q;
`else
  logic unused_retiring;
  assign unused_retiring = retiring;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: self-checking bench for control_unit.
// Table vectors with hand-derived latency and final-cycle flags, hand
// sequences for reset, IN stalls and HALT, and randomized instruction
// streams compared cycle by cycle against a per-instruction trace model.
module tb_control_unit;

  logic       clock;
  logic       reset;
  logic [5:0] opcode;
  logic       flagBRANCH;
  logic       in_valid;
  logic [2:0] State;
  logic [1:0] flagRF, flagALU, flagPC, flagDM, flagMUXRD;
  logic       flagJR, flagJAL, flagLI, flagRR;
  logic       in_ack, out_valid, halted, illegal;
`ifdef CU_RETIRE_COUNT_EN
  logic [31:0] retired;
`endif

  control_unit dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .flagBRANCH (flagBRANCH),
    .in_valid   (in_valid),
    .State      (State),
    .flagRF     (flagRF),
    .flagALU    (flagALU),
    .flagPC     (flagPC),
    .flagDM     (flagDM),
    .flagMUXRD  (flagMUXRD),
    .flagJR     (flagJR),
    .flagJAL    (flagJAL),
    .flagLI     (flagLI),
    .flagRR     (flagRR),
    .in_ack     (in_ack),
    .out_valid  (out_valid),
    .halted     (halted),
    .illegal    (illegal)
`ifdef CU_RETIRE_COUNT_EN
    ,
    .retired    (retired)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] state;
    logic [1:0] rf, alu, pc, dm, mux;
    logic       jr, jal, li, rr, in_ack, out_valid, halted, illegal;
  } exp_t;

  typedef struct {
    int op; int br; int wait_n; int cycles; int pc; int rf; int mux; int dm;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   retired_model = 0;
  exp_t exp_q[$];
  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t sample();
    exp_t s;
    s.state = State;   s.rf = flagRF;   s.alu = flagALU; s.pc = flagPC;
    s.dm = flagDM;     s.mux = flagMUXRD;
    s.jr = flagJR;     s.jal = flagJAL; s.li = flagLI;   s.rr = flagRR;
    s.in_ack = in_ack; s.out_valid = out_valid;
    s.halted = halted; s.illegal = illegal;
    return s;
  endfunction

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e = '0;
    e.state = st;
    return e;
  endfunction

  task automatic check_retired(input string name);
`ifdef CU_RETIRE_COUNT_EN
    check(name, retired, 32'(retired_model));
`endif
  endtask

  // Reference model: the expected per-cycle outputs of one instruction,
  // written as the instruction's path (FETCH, DECODE, EXEC, then its phases).
  task automatic build_trace(input int op, input bit br, input int wait_n, input int halt_n);
    exp_t e;
    bit   rr;
    exp_q.delete();
    exp_q.push_back(blank(3'd0));
    exp_q.push_back(blank(3'd1));
    rr = (op == 16) || (op == 17);
    e = blank(3'd2);
    e.rr = rr;
    if (op > 17 || op == 12) begin
      exp_q.push_back(e);
      repeat (halt_n) begin
        e = blank(3'd6); e.halted = 1'b1; e.illegal = (op > 17);
        exp_q.push_back(e);
      end
      return;
    end
    case (op)
      0, 4, 5: begin
        e.alu = (op == 0) ? 2'd1 : (op == 4) ? 2'd2 : 2'd3;
        exp_q.push_back(e);
        e.state = 3'd4; e.rf = 2'd1; e.pc = 2'd1;
        exp_q.push_back(e);
      end
      1, 16: begin
        exp_q.push_back(e);
        e = blank(3'd3); e.rr = rr; e.dm = 2'd1;
        exp_q.push_back(e);
        e.state = 3'd4; e.rf = 2'd1; e.mux = 2'd1; e.pc = 2'd1;
        exp_q.push_back(e);
      end
      3, 17: begin
        exp_q.push_back(e);
        e = blank(3'd3); e.rr = rr; e.dm = 2'd2; e.pc = 2'd1;
        exp_q.push_back(e);
      end
      2: begin
        exp_q.push_back(e);
        e = blank(3'd4); e.li = 1'b1; e.rf = 2'd1; e.pc = 2'd1;
        exp_q.push_back(e);
      end
      6, 7: begin
        e.alu = 2'd1;
        exp_q.push_back(e);
        e = blank(3'd4);
        e.pc = ((op == 6) == br) ? 2'd2 : 2'd1;
        exp_q.push_back(e);
      end
      8:  begin e.pc = 2'd2; exp_q.push_back(e); end
      9:  begin e.pc = 2'd2; e.jr = 1'b1; exp_q.push_back(e); end
      10: begin
        exp_q.push_back(e);
        e = blank(3'd4); e.jal = 1'b1; e.mux = 2'd3; e.rf = 2'd1; e.pc = 2'd2;
        exp_q.push_back(e);
      end
      11: begin e.pc = 2'd1; exp_q.push_back(e); end
      13: begin e.rf = 2'd2; e.pc = 2'd1; exp_q.push_back(e); end
      15: begin e.out_valid = 1'b1; e.pc = 2'd1; exp_q.push_back(e); end
      14: begin
        exp_q.push_back(e);
        repeat (wait_n) exp_q.push_back(blank(3'd5));
        e = blank(3'd5); e.in_ack = 1'b1; e.rf = 2'd1; e.mux = 2'd2; e.pc = 2'd1;
        exp_q.push_back(e);
      end
      default: ;
    endcase
  endtask

  // Applies the model trace starting at a FETCH cycle; opcode, flagBRANCH
  // and in_valid carry junk outside the cycles where they matter.
  task automatic run_trace(input string name, input int op, input bit br);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      opcode     = (i == 1) ? 6'(op) : 6'($urandom);
      flagBRANCH = (i == 2) ? br : 1'($urandom);
      in_valid   = (exp_q[i].state == 3'd5) ? (i == n - 1) : 1'($urandom);
      @(negedge clock);
      check($sformatf("%s op%0d cyc%0d", name, op, i), 32'(sample()), 32'(exp_q[i]));
      @(posedge clock); #1;
    end
    if (exp_q[n-1].state != 3'd6) begin
      retired_model++;
      check_retired($sformatf("%s op%0d retired", name, op));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; opcode = '0; flagBRANCH = 1'b0; in_valid = 1'b0;
    #1;
    check("reset outputs", 32'(sample()), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    retired_model = 0;
    check_retired("reset retired");
  endtask

  task automatic run_vec(input int k);
    int   cyc, seen;
    exp_t last;
    bit   done;
    cyc = 0; seen = 0; done = 0; last = '0;
    while (!done) begin
      opcode     = (cyc == 1) ? 6'(vecs[k].op) : 6'($urandom);
      flagBRANCH = (cyc == 2) ? 1'(vecs[k].br) : 1'($urandom);
      if (State == 3'd5) begin
        in_valid = (seen >= vecs[k].wait_n);
        seen++;
      end else begin
        in_valid = 1'($urandom);
      end
      @(negedge clock);
      last = sample();
      cyc++;
      @(posedge clock); #1;
      if (State == 3'd0 || cyc >= 20) done = 1;
    end
    check($sformatf("vec%0d op%0d latency", k, vecs[k].op), 32'(cyc), 32'(vecs[k].cycles));
    check($sformatf("vec%0d op%0d last pc", k, vecs[k].op), 32'(last.pc), 32'(vecs[k].pc));
    check($sformatf("vec%0d op%0d last rf", k, vecs[k].op), 32'(last.rf), 32'(vecs[k].rf));
    check($sformatf("vec%0d op%0d last mux", k, vecs[k].op), 32'(last.mux), 32'(vecs[k].mux));
    check($sformatf("vec%0d op%0d last dm", k, vecs[k].op), 32'(last.dm), 32'(vecs[k].dm));
    retired_model++;
    check_retired($sformatf("vec%0d retired", k));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   states[5];
    int   w5, acks;
    logic [1:0] ack_rf, ack_mux;
    exp_t h;

    //           op br wait cyc pc rf mux dm
    vecs[0]  = '{0,  0, 0, 4, 1, 1, 0, 0};
    vecs[1]  = '{4,  0, 0, 4, 1, 1, 0, 0};
    vecs[2]  = '{5,  1, 0, 4, 1, 1, 0, 0};
    vecs[3]  = '{1,  0, 0, 5, 1, 1, 1, 1};
    vecs[4]  = '{16, 0, 0, 5, 1, 1, 1, 1};
    vecs[5]  = '{3,  0, 0, 4, 1, 0, 0, 2};
    vecs[6]  = '{17, 0, 0, 4, 1, 0, 0, 2};
    vecs[7]  = '{2,  0, 0, 4, 1, 1, 0, 0};
    vecs[8]  = '{6,  1, 0, 4, 2, 0, 0, 0};
    vecs[9]  = '{6,  0, 0, 4, 1, 0, 0, 0};
    vecs[10] = '{7,  1, 0, 4, 1, 0, 0, 0};
    vecs[11] = '{7,  0, 0, 4, 2, 0, 0, 0};
    vecs[12] = '{8,  0, 0, 3, 2, 0, 0, 0};
    vecs[13] = '{9,  0, 0, 3, 2, 0, 0, 0};
    vecs[14] = '{10, 0, 0, 4, 2, 1, 3, 0};
    vecs[15] = '{11, 0, 0, 3, 1, 0, 0, 0};
    vecs[16] = '{13, 0, 0, 3, 1, 2, 0, 0};
    vecs[17] = '{15, 0, 0, 3, 1, 0, 0, 0};
    vecs[18] = '{14, 0, 0, 4, 1, 1, 2, 0};
    vecs[19] = '{14, 0, 2, 6, 1, 1, 2, 0};

    do_reset();
    for (int k = 0; k < 20; k++) run_vec(k);

    // ALU instruction state walk 0,1,2,4,0 with RF/PC active only in WB.
    do_reset();
    states = '{0, 1, 2, 4, 0};
    for (int i = 0; i < 5; i++) begin
      opcode = (i == 1) ? 6'd0 : 6'($urandom);
      @(negedge clock);
      check($sformatf("alu walk state %0d", i), 32'(State), 32'(states[i]));
      check($sformatf("alu walk rf %0d", i), 32'(flagRF), (i == 3) ? 32'd1 : 32'd0);
      check($sformatf("alu walk pc %0d", i), 32'(flagPC), (i == 3) ? 32'd1 : 32'd0);
      @(posedge clock); #1;
    end

    // Reset in MEM of LW: outputs clear at once, no write after release.
    do_reset();
    opcode = 6'($urandom);
    @(negedge clock); @(posedge clock); #1;
    opcode = 6'd1;
    @(negedge clock); @(posedge clock); #1;
    @(negedge clock); @(posedge clock); #1;
    check("lw in mem", 32'(State), 32'd3);
    #2 reset = 1'b1;
    #1 check("reset mid mem outputs", 32'(sample()), 32'd0);
    @(posedge clock); @(negedge clock);
    reset = 1'b0; opcode = 6'd11;
    #1 check("post reset state", 32'(State), 32'd0);
    check("post reset rf", 32'(flagRF), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("post reset decode state", 32'(State), 32'd1);
    check("post reset decode rf/dm", 32'({flagRF, flagDM}), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("post reset nop state", 32'(State), 32'd2);
    check("post reset nop pc", 32'(flagPC), 32'd1);
    check("post reset nop rf", 32'(flagRF), 32'd0);

    // IN with in_valid low for three WAIT_IN cycles, then high.
    do_reset();
    w5 = 0; acks = 0; ack_rf = '0; ack_mux = '0;
    for (int i = 0; i < 12; i++) begin
      opcode   = (i == 1) ? 6'd14 : 6'($urandom);
      in_valid = (State == 3'd5) ? (w5 >= 3) : 1'b0;
      @(negedge clock);
      if (State == 3'd5) w5++;
      if (in_ack) begin acks++; ack_rf = flagRF; ack_mux = flagMUXRD; end
      @(posedge clock); #1;
      if (i > 2 && State == 3'd0) break;
    end
    check("in wait cycles", 32'(w5), 32'd4);
    check("in ack pulses", 32'(acks), 32'd1);
    check("in ack rf", 32'(ack_rf), 32'd1);
    check("in ack mux", 32'(ack_mux), 32'd2);

    // HLT then opcode 0 and toggling in_valid: HALT is absorbing.
    do_reset();
    build_trace(12, 1'b0, 0, 2);
    run_trace("hlt", 12, 1'b0);
    h = blank(3'd6); h.halted = 1'b1;
    for (int i = 0; i < 6; i++) begin
      opcode = 6'd0; in_valid = i[0];
      @(negedge clock);
      check($sformatf("halt hold %0d", i), 32'(sample()), 32'(h));
      @(posedge clock); #1;
    end

    // Undefined opcode 63: illegal and halted from the HALT cycle.
    do_reset();
    build_trace(63, 1'b0, 0, 3);
    run_trace("illegal", 63, 1'b0);

    // Three NOPs then HLT: retired count stops at three.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      build_trace(11, 1'b0, 0, 0);
      run_trace("nop", 11, 1'b0);
    end
    build_trace(12, 1'b0, 0, 3);
    run_trace("nop hlt", 12, 1'b0);
    check_retired("retired after hlt");

    // Random instruction stream against the trace model.
    do_reset();
    for (int n = 0; n < 150; n++) begin
      int op;
      bit br;
      op = $urandom_range(0, 17);
      if (op == 12) op = 11;
      br = 1'($urandom);
      build_trace(op, br, $urandom_range(0, 3), 0);
      run_trace("rand", op, br);
    end
    build_trace(12, 1'b0, 0, 4);
    run_trace("rand end", 12, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle sequencer for the processor datapath.
- Takes the current opcode and the branch-compare result.
- Drives the datapath state code and all control flags: register file, ALU, PC, data memory, RD mux, JR, JAL, LI, RR.
- Also owns the IN/OUT port handshake and the halt condition.

Parameters:
- flag, 2, width of 2-bit control flags
- opFunc, 6, opcode width
- st, 3, state code width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  opFunc  current instruction opcode from datapath
- flagBRANCH  in  1  compare result, 1 = operands equal
- in_valid  in  1  external input word on IN bus is valid
- State  out  st  current FSM state code
- flagRF  out  flag  00 none, 01 write RD, 10 move, 11 reserved
- flagALU  out  flag  00 none, 01 arith/logic/compare by funct, 10 shift right, 11 shift left
- flagPC  out  flag  00 hold, 01 PC+1, 10 load target, 11 reserved
- flagDM  out  flag  00 none, 01 read, 10 write
- flagMUXRD  out  flag  00 ALU, 01 memory, 10 IN bus, 11 return address
- flagJR, flagJAL, flagLI, flagRR  out  1 each  datapath mode selects
- in_ack  out  1  one-cycle pulse, IN word consumed
- out_valid  out  1  one-cycle pulse, OUT bus (RS value) valid
- halted  out  1  processor stopped
- illegal  out  1  sticky, undefined opcode seen

Behaviour:
- Reset (async):
  - State = FETCH(0); all flags 0; in_ack/out_valid/halted/illegal 0.
  - op_q = 0, branch_q = 0.
  - Reset mid-instruction abandons it; no partial writes are issued after reset deasserts.
- State codes: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, WAIT_IN 5, HALT 6.
- Register rules:
  - op_q latches opcode in DECODE; EXEC/MEM/WB/WAIT_IN decode from op_q only.
  - branch_q latches flagBRANCH at end of EXEC.
- Outputs are registered-state Moore decodes of (State, op_q); all flags 0 in FETCH, DECODE and HALT.
- FETCH -> DECODE -> EXEC always. Each opcode then follows one path:
  - 0 ALU, 4 SRL, 5 SLL: EXEC flagALU=01/10/11 -> WB flagALU held, flagRF=01, MUXRD=00, flagPC=01 -> FETCH. Latency 4.
  - 1 LW, 16 LOADR: EXEC -> MEM flagDM=01 -> WB flagDM=01, MUXRD=01, flagRF=01, flagPC=01 -> FETCH. flagRR=1 throughout for LOADR. Latency 5.
  - 3 SW, 17 STORER: EXEC -> MEM flagDM=10, flagPC=01 -> FETCH. flagRR=1 for STORER. Latency 4.
  - 2 LI: EXEC -> WB flagLI=1, flagRF=01, flagPC=01 -> FETCH.
  - 6 BEQ, 7 BNQ: EXEC flagALU=01 -> WB flagPC=10 if taken else 01 -> FETCH. Taken when branch_q=1 (BEQ) or branch_q=0 (BNQ).
  - 8 J: EXEC flagPC=10 -> FETCH.
  - 9 JR: EXEC flagPC=10, flagJR=1 -> FETCH.
  - 10 JAL: EXEC -> WB flagJAL=1, MUXRD=11, flagRF=01, flagPC=10 -> FETCH. RD write and PC load happen on the same edge.
  - 11 NOP: EXEC flagPC=01 -> FETCH.
  - 13 MOVE: EXEC flagRF=10, flagPC=01 -> FETCH.
  - 15 OUT: EXEC out_valid=1, flagPC=01 -> FETCH.
  - 14 IN: EXEC -> WAIT_IN. WAIT_IN stalls with all flags 0 while in_valid=0. When in_valid=1: in_ack=1, flagRF=01, MUXRD=10, flagPC=01 -> FETCH. An in_valid already high on WAIT_IN entry is accepted in that same cycle.
  - 12 HLT: EXEC -> HALT.
  - Opcode > 17: EXEC -> HALT, illegal set.
- HALT:
  - Absorbing; halted=1; PC held (flagPC=00). Only reset exits.
  - in_valid is ignored.
- At most one of flagRF write or flagDM write is active in any cycle.

Optional Feature:
- Macro CU_RETIRE_COUNT_EN.
- Defined:
  - Adds output retired (32 bits), reset to 0.
  - Increments on every transition into FETCH that completes an instruction; wraps at 2^32-1 -> 0.
  - Frozen in HALT.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package cu_pkg holds:
  - state code constants;
  - opcode constants 0..17;
  - flag encodings for flagRF, flagALU, flagPC, flagDM, flagMUXRD.
- One natural sub-module: cu_decode, the combinational (State, op_q, branch_q, in_valid) -> flag vector decoder.
- The FSM, op_q/branch_q registers and optional counter stay in control_unit.

Test Plan:
- Reset asserted during MEM of LW -> all outputs 0 immediately; State=0 at first edge after release; no flagRF write seen.
- opcode=0 -> State 0,1,2,4,0; flagRF=01 only in the WB cycle; flagPC=01 only in WB.
- BEQ with flagBRANCH=1 -> WB flagPC=10. BNQ with flagBRANCH=1 -> WB flagPC=01.
- IN with in_valid low for 3 cycles then high -> State=5 for 4 cycles; in_ack single pulse with flagRF=01, MUXRD=10.
- opcode=12, then opcode=0 presented, in_valid toggling -> State stays 6, halted=1, all flags 0, no in_ack.
- opcode=63 -> illegal=1 and halted=1 from the HALT cycle. With CU_RETIRE_COUNT_EN: after 3 NOPs then HLT, retired=3.
